// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD core among NREQ requesters.
// Issues START, waits for DONE or watchdog expiry, then ACKs the winner.
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      res_y,
    output logic [2*WIDTH-1:0]    res_lcm,
    output logic                  res_error,
    output logic                  res_to,
    output logic [IDW-1:0]        res_id,
    output logic                  busy,
    output logic                  gcd_start,
    output logic [WIDTH-1:0]      gcd_a,
    output logic [WIDTH-1:0]      gcd_b,
    input  logic                  gcd_done,
    input  logic [WIDTH-1:0]      gcd_y,
    input  logic                  gcd_error,
    input  logic [2*WIDTH-1:0]    gcd_lcm
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  PTR_INIT = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nx;
    logic [IDW-1:0] id;
    logic [IDW-1:0] id_nx;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           win_vld;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;
    logic           load_ops;
    logic           cap_done;
    logic           cap_to;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // First requesting index strictly after the last grant, wrapping.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign sel_a = req_a[win*WIDTH +: WIDTH];
    assign sel_b = req_b[win*WIDTH +: WIDTH];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        id_nx    = id;
        cnt_nx   = cnt;
        load_ops = 1'b0;
        cap_done = 1'b0;
        cap_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx = ISSUE;
                    ptr_nx   = win;
                    id_nx    = win;
                    load_ops = 1'b1;
                end
            end
            ISSUE: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt != '1) begin
                    cnt_nx = cnt + CW'(1);
                end
                // A DONE arriving in the expiry cycle still wins.
                if (gcd_done) begin
                    cap_done = 1'b1;
                    state_nx = RESP;
                end else if (cnt == CNT_LAST) begin
                    cap_to   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= PTR_INIT;
            id    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            id    <= id_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcd_a <= '0;
            gcd_b <= '0;
        end else if (load_ops) begin
            gcd_a <= sel_a;
            gcd_b <= sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y     <= '0;
            res_lcm   <= '0;
            res_error <= 1'b0;
            res_to    <= 1'b0;
            res_id    <= '0;
        end else begin
            unique case (1'b1)
                cap_done: begin
                    res_y     <= gcd_y;
                    res_lcm   <= gcd_lcm;
                    res_error <= gcd_error;
                    res_to    <= 1'b0;
                    res_id    <= id;
                end
                cap_to: begin
                    res_y     <= '0;
                    res_lcm   <= '0;
                    res_error <= 1'b1;
                    res_to    <= 1'b1;
                    res_id    <= id;
                end
                default: begin
                end
            endcase
        end
    end

    assign gcd_start = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign ack       = (state == RESP) ? (ONE << id) : '0;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Randomized bench for gcd_arbiter with a behavioural core and
// round-robin reference model.
module tb_gcd_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      res_y;
    logic [2*WIDTH-1:0]    res_lcm;
    logic                  res_error;
    logic                  res_to;
    logic [IDW-1:0]        res_id;
    logic                  busy;
    logic                  gcd_start;
    logic [WIDTH-1:0]      gcd_a;
    logic [WIDTH-1:0]      gcd_b;
    logic                  gcd_done;
    logic [WIDTH-1:0]      gcd_y;
    logic                  gcd_error;
    logic [2*WIDTH-1:0]    gcd_lcm;

    gcd_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .TIMEOUT(TIMEOUT),
        .IDW(IDW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_a(req_a),
        .req_b(req_b),
        .ack(ack),
        .res_y(res_y),
        .res_lcm(res_lcm),
        .res_error(res_error),
        .res_to(res_to),
        .res_id(res_id),
        .busy(busy),
        .gcd_start(gcd_start),
        .gcd_a(gcd_a),
        .gcd_b(gcd_b),
        .gcd_done(gcd_done),
        .gcd_y(gcd_y),
        .gcd_error(gcd_error),
        .gcd_lcm(gcd_lcm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ptr_m;
    logic [WIDTH-1:0]   opa [NREQ];
    logic [WIDTH-1:0]   opb [NREQ];
    logic [WIDTH-1:0]   e_y;
    logic [2*WIDTH-1:0] e_lcm;
    logic               e_err;
    logic               e_to;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int x, y, t;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return WIDTH'(x);
    endfunction

    task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        req[i] = 1'b1;
        opa[i] = a;
        opb[i] = b;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic set_req(input int i);
        logic [WIDTH-1:0] a, b;
        a = ($urandom_range(0, 7) == 0) ? '0 : 8'($urandom);
        b = ($urandom_range(0, 7) == 0) ? '0 : 8'($urandom);
        set_op(i, a, b);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        gcd_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
    endtask

    // One grant from the IDLE cycle to the IDLE cycle after its ACK.
    // delay: DONE this many cycles after START; outside 1..TIMEOUT never.
    task automatic serve(input int delay, input bit reraise, output int id);
        int exp_id, exp_ack, n;
        logic [WIDTH-1:0]   a, b, cy;
        logic [2*WIDTH-1:0] cl;
        logic ce, early;
        exp_id = rr_pick(req, ptr_m);
        id = -1;
        if (exp_id < 0) exp_id = 0;
        a = opa[exp_id];
        b = opb[exp_id];
        n = 0;
        do begin
            step();
            gcd_done = 1'b0;
            n++;
        end while (!gcd_start && n < 8);
        check("start_lat", n, 1);
        if (!gcd_start) return;
        check("gcd_a", gcd_a, a);
        check("gcd_b", gcd_b, b);
        ce = (a == '0) || (b == '0);
        if (ce) begin
            cy = '0;
            cl = '0;
        end else begin
            cy = gcd_ref(a, b);
            cl = 16'((int'(a) * int'(b)) / int'(cy));
        end
        if (delay >= 1 && delay <= TIMEOUT) begin
            exp_ack = delay + 1;
            e_y = cy; e_lcm = cl; e_err = ce; e_to = 1'b0;
        end else begin
            exp_ack = TIMEOUT + 1;
            e_y = '0; e_lcm = '0; e_err = 1'b1; e_to = 1'b1;
        end
        early = 1'b0;
        for (int k = 1; k <= exp_ack; k++) begin
            step();
            if (k < exp_ack && (ack != '0 || gcd_start)) early = 1'b1;
            gcd_done  = 1'b0;
            gcd_y     = 8'($urandom);
            gcd_lcm   = 16'($urandom);
            gcd_error = 1'($urandom);
            if (k == delay) begin
                gcd_done  = 1'b1;
                gcd_y     = cy;
                gcd_lcm   = cl;
                gcd_error = ce;
            end else if (k == exp_ack) begin
                gcd_done = 1'($urandom);
            end
        end
        check("early_ack_or_start", early, 0);
        check("ack", ack, 1 << exp_id);
        check("res_id", res_id, exp_id);
        check("res_y", res_y, e_y);
        check("res_lcm", res_lcm, e_lcm);
        check("res_error", res_error, e_err);
        check("res_to", res_to, e_to);
        check("busy_resp", busy, 1);
        id = int'(res_id);
        req[exp_id] = 1'b0;
        ptr_m = exp_id;
        step();
        gcd_done = 1'($urandom);
        check("busy_idle", busy, 0);
        check("ack_idle", ack, 0);
        check("hold_lcm", res_lcm, e_lcm);
        check("hold_to", res_to, e_to);
        if (reraise) set_req(exp_id);
    endtask

    int id;
    int order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        req = '0; req_a = '0; req_b = '0;
        gcd_done = 1'b0; gcd_y = '0; gcd_error = 1'b0; gcd_lcm = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        step();
        step();
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_start", gcd_start, 0);
        check("rst_gcd_a", gcd_a, 0);
        check("rst_res_y", res_y, 0);
        check("rst_res_id", res_id, 0);
        rst_n = 1'b1;
        ptr_m = NREQ - 1;

        set_op(0, 8'd78, 8'd23);
        serve(5, 1'b0, id);
        check("single_id", id, 0);
        check("single_y", res_y, 1);
        check("single_lcm", res_lcm, 1794);

        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i);
        for (int j = 0; j < 6; j++) begin
            serve($urandom_range(1, 6), 1'b1, id);
            check("fair_order", id, order[j]);
        end

        do_reset();
        set_op(2, 8'd101, 8'd0);
        serve(4, 1'b0, id);
        check("err_id", id, 2);
        check("err_flag", res_error, 1);
        check("err_to", res_to, 0);

        set_op(0, 8'd40, 8'd24);
        serve(-1, 1'b0, id);
        check("wd_to", res_to, 1);
        set_op(1, 8'd40, 8'd24);
        serve(TIMEOUT, 1'b0, id);
        check("wd_edge_to", res_to, 0);
        check("wd_edge_y", res_y, 8);

        do_reset();
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) set_req(i);
            end
            if (req == '0) set_req($urandom_range(0, NREQ - 1));
            serve($urandom_range(1, 18), 1'($urandom), id);
        end

        do_reset();
        set_op(2, 8'd12, 8'd18);
        serve(3, 1'b0, id);
        check("y_12_18", res_y, 6);
        for (int k = 0; k < 3; k++) begin
            gcd_done = 1'b1;
            gcd_y = 8'($urandom);
            gcd_lcm = 16'($urandom);
            step();
            check("spur_busy", busy, 0);
            check("spur_ack", ack, 0);
            check("spur_y", res_y, 6);
            check("spur_lcm", res_lcm, 36);
        end
        gcd_done = 1'b0;

        set_op(1, 8'd9, 8'd6);
        set_op(3, 8'd10, 8'd4);
        step();
        check("mid_start", gcd_start, 1);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_ack", ack, 0);
        check("mid_busy", busy, 0);
        check("mid_start0", gcd_start, 0);
        check("mid_gcd_a", gcd_a, 0);
        check("mid_gcd_b", gcd_b, 0);
        check("mid_res_y", res_y, 0);
        check("mid_res_lcm", res_lcm, 0);
        check("mid_res_err", res_error, 0);
        check("mid_res_to", res_to, 0);
        check("mid_res_id", res_id, 0);
        step();
        step();
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
        gcd_done = 1'b1;
        gcd_y = 8'd99;
        serve(2, 1'b0, id);
        check("rst_first_id", id, 1);
        serve(4, 1'b0, id);
        check("rst_second_id", id, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
